// File: rtl/blackparrot_fpga_host_write_to_fifo_pkg.sv
// Shared AXI-Lite response codes and channel widths for the host-side write path.
package blackparrot_fpga_host_write_to_fifo_pkg;

  localparam int unsigned axi_prot_width_gp = 3;
  localparam int unsigned axi_resp_width_gp = 2;

  typedef enum logic [axi_resp_width_gp-1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/blackparrot_fpga_host_csr_decode.sv
// Matches an address against the CSR table; lowest matching index wins.
module blackparrot_fpga_host_csr_decode #(
  parameter int unsigned ELS_P        = 1,
  parameter int unsigned ADDR_WIDTH_P = 64,
  parameter logic [ELS_P-1:0][ADDR_WIDTH_P-1:0] csr_addr_p = '0
) (
  input  logic                    v,
  input  logic [ADDR_WIDTH_P-1:0] addr,
  output logic [ELS_P-1:0]        grant,
  output logic                    invalid
);

  logic [ELS_P-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(ELS_P); i++) begin
      sel[i] = (addr == csr_addr_p[i]);
    end
  end

  // Isolate the lowest set bit so the grant stays one-hot even with duplicate table entries.
  assign grant   = sel & (~sel + ELS_P'(1));
  assign invalid = v & ~|sel;

endmodule

// File: rtl/blackparrot_fpga_host_write_to_fifo.sv
// AXI-Lite write slave: buffers AW/W, decodes the address and pushes data into the
// selected outbound FIFO interface, returning one OKAY response per write.
module blackparrot_fpga_host_write_to_fifo
  import blackparrot_fpga_host_write_to_fifo_pkg::*;
#(
  parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
  parameter int unsigned S_AXIL_DATA_WIDTH = 32,
  parameter int unsigned CSR_ELS_P         = 1,
  parameter logic [CSR_ELS_P-1:0][S_AXIL_ADDR_WIDTH-1:0] csr_addr_p = '0
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]                 s_axil_awaddr,
  input  logic                                         s_axil_awvalid,
  output logic                                         s_axil_awready,
  input  logic [axi_prot_width_gp-1:0]                 s_axil_awprot,

  input  logic [S_AXIL_DATA_WIDTH-1:0]                 s_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0]               s_axil_wstrb,
  input  logic                                         s_axil_wvalid,
  output logic                                         s_axil_wready,

  output logic [axi_resp_width_gp-1:0]                 s_axil_bresp,
  output logic                                         s_axil_bvalid,
  input  logic                                         s_axil_bready,

  output logic [CSR_ELS_P-1:0]                         fifo_v_o,
  input  logic [CSR_ELS_P-1:0]                         fifo_ready_i,
  output logic [CSR_ELS_P-1:0][S_AXIL_DATA_WIDTH-1:0]  fifo_data_o
);

  logic                         aw_v, aw_full, aw_enq, aw_wp, aw_rp;
  logic [1:0]                   aw_cnt;
  logic [S_AXIL_ADDR_WIDTH-1:0] aw_mem [2];
  logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr;

  logic                         w_v, w_full, w_enq, w_wp, w_rp;
  logic [1:0]                   w_cnt;
  logic [S_AXIL_DATA_WIDTH-1:0] w_mem [2];
  logic [S_AXIL_DATA_WIDTH-1:0] w_data;

  logic [CSR_ELS_P-1:0]         grant;
  logic                         invalid, b_free, commit, bvalid_r;

  // Protection bits and byte strobes carry no meaning for full-word CSR pushes.
  logic unused_inputs;
  assign unused_inputs = ^{s_axil_awprot, s_axil_wstrb};

  // Two-entry AW buffer
  assign aw_v           = (aw_cnt != 2'd0);
  assign aw_full        = (aw_cnt == 2'd2);
  assign s_axil_awready = ~aw_full & ~reset_i;
  assign aw_enq         = s_axil_awvalid & s_axil_awready;
  assign aw_addr        = aw_mem[aw_rp];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_cnt <= 2'd0;
      aw_wp  <= 1'b0;
      aw_rp  <= 1'b0;
    end else begin
      if (aw_enq) aw_wp <= ~aw_wp;
      if (commit) aw_rp <= ~aw_rp;
      aw_cnt <= aw_cnt + 2'(aw_enq) - 2'(commit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_enq) aw_mem[aw_wp] <= s_axil_awaddr;
  end

  // Two-entry W buffer
  assign w_v           = (w_cnt != 2'd0);
  assign w_full        = (w_cnt == 2'd2);
  assign s_axil_wready = ~w_full & ~reset_i;
  assign w_enq         = s_axil_wvalid & s_axil_wready;
  assign w_data        = w_mem[w_rp];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_cnt <= 2'd0;
      w_wp  <= 1'b0;
      w_rp  <= 1'b0;
    end else begin
      if (w_enq)  w_wp <= ~w_wp;
      if (commit) w_rp <= ~w_rp;
      w_cnt <= w_cnt + 2'(w_enq) - 2'(commit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) w_mem[w_wp] <= s_axil_wdata;
  end

  blackparrot_fpga_host_csr_decode #(
    .ELS_P        (CSR_ELS_P),
    .ADDR_WIDTH_P (S_AXIL_ADDR_WIDTH),
    .csr_addr_p   (csr_addr_p)
  ) decode (
    .v       (aw_v),
    .addr    (aw_addr),
    .grant   (grant),
    .invalid (invalid)
  );

  // A write may only retire when its response can land in the single B slot.
  assign b_free      = ~bvalid_r | s_axil_bready;
  assign fifo_v_o    = {CSR_ELS_P{aw_v & w_v & b_free}} & grant;
  assign fifo_data_o = {CSR_ELS_P{w_data}};
  assign commit      = aw_v & w_v & b_free & (invalid | (|(grant & fifo_ready_i)));

  always_ff @(posedge clk_i) begin
    if (reset_i)            bvalid_r <= 1'b0;
    else if (commit)        bvalid_r <= 1'b1;
    else if (s_axil_bready) bvalid_r <= 1'b0;
  end

  assign s_axil_bvalid = bvalid_r;
  assign s_axil_bresp  = e_axi_resp_okay;

endmodule

// File: doc/blackparrot_fpga_host_write_to_fifo.md
Name: blackparrot_fpga_host_write_to_fifo

Overview:
- AXI4-Lite write slave on the host side of the FPGA shell; the write-direction counterpart of the host CSR read path.
- Decodes each AXIL write address against a table of CSR addresses and pushes the write data into the matching outbound FIFO interface, which feeds BlackParrot-side consumers.
- Returns one B response per write. Writes to unmapped addresses are accepted and discarded.

Parameters:
- S_AXIL_ADDR_WIDTH, 64: AXIL address width.
- S_AXIL_DATA_WIDTH, 32: AXIL data width, and the width of each FIFO data lane.
- CSR_ELS_P, 1: number of CSR/FIFO channels.
- csr_addr_p, '{0}: array [CSR_ELS_P] of S_AXIL_ADDR_WIDTH addresses; entry i selects channel i.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  S_AXIL_ADDR_WIDTH  write address.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_awprot  in  3  ignored.
- s_axil_wdata  in  S_AXIL_DATA_WIDTH  write data.
- s_axil_wstrb  in  S_AXIL_DATA_WIDTH/8  ignored; full-word writes only.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  always e_axi_resp_okay.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- fifo_v_o  out  CSR_ELS_P  per-channel push valid.
- fifo_ready_i  in  CSR_ELS_P  per-channel consumer ready.
- fifo_data_o  out  CSR_ELS_P x S_AXIL_DATA_WIDTH  per-channel data; every lane carries the buffered wdata.

Behaviour:
- AW and W are buffered independently, each in a 2-entry buffer (bsg_two_fifo).
  - awready/wready = buffer not full; forced 0 while reset_i is high.
  - AW and W may arrive in any order or cycle offset.
- Decode: sel[i] = (aw_addr == csr_addr_p[i]). Fixed priority, lowest index wins; the resulting grant is one-hot.
  - invalid = aw_v & ~|sel.
- b_free = ~bvalid_r | s_axil_bready.
- fifo_v_o[i] = aw_v & w_v & grant[i] & b_free.
  - Must not depend on fifo_ready_i.
  - Transfer on channel i occurs when fifo_v_o[i] & fifo_ready_i[i].
- commit = aw_v & w_v & b_free & (invalid | |(grant & fifo_ready_i)).
  - On commit, both buffers dequeue in the same cycle.
  - An invalid-address write drops its data and never asserts fifo_v_o.
- B channel: single registered response slot bvalid_r.
  - Set on commit.
  - Cleared when bvalid & bready and there is no commit in the same cycle.
  - Commit and bready in the same cycle keep bvalid_r = 1 (back-to-back responses).
- Latency with AW/W presented together at cycle 0 and consumer ready:
  - fifo_v_o high at cycle 1; push occurs at cycle 1.
  - bvalid high at cycle 2.
- Backpressure:
  - Consumer not ready: the write holds in the buffers; once both buffers are full, awready/wready drop.
  - bready low with bvalid high: no further commits. Up to 2 AW and 2 W beats may still be accepted.
- Ordering: writes commit strictly in AW arrival order, one per cycle maximum.
- Reset values: bvalid 0, fifo_v_o 0, awready 0, wready 0.
  - Reset asserted mid-transaction discards all buffered AW/W and any pending B.
  - Partial transactions are not replayed.
- bresp is constant OKAY for both mapped and unmapped addresses.

Decomposition:
- e_axi_resp_okay comes from bsg_axi_pkg; no new package is needed.
- Reuse bsg_two_fifo for the AW and W buffers, and bsg_arb_fixed (lo_to_hi) for the decode grant.
- One natural sub-module: blackparrot_fpga_host_csr_decode, which takes an address and produces grant[CSR_ELS_P] plus invalid. It is shareable with the read path.
- The B slot is inline logic.

Test Plan:
- CSR_ELS_P=2, csr_addr_p={0x20,0x10}, all ready. Write 0x10 / 0xDEADBEEF with AW and W in the same cycle -> fifo_v_o=2'b01 at cycle 1 with data 0xDEADBEEF; bvalid at cycle 2 with bresp=0.
- W arrives 3 cycles before AW (addr 0x20, data 0x5) -> no push until AW arrives; then exactly one push on channel 1 with data 0x5 and one B response.
- Write to 0x30 (unmapped) -> fifo_v_o stays 0; bvalid asserts with OKAY; both buffers drain.
- fifo_ready_i[0]=0 while 4 writes to 0x10 are issued -> after 2 AW/W beats are buffered, awready/wready drop. Releasing ready -> pushes occur in issue order with data 1,2,3,4 and 4 B responses.
- bready held 0 -> after 1 commit, fifo_v_o stays 0. Raising bready -> back-to-back bvalid with a new commit in the same cycle.
- Reset pulsed with 1 AW buffered and bvalid high -> after reset, bvalid=0 and fifo_v_o=0; the next full write completes normally.
